// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with single-cycle logic/arithmetic ops, bit-serial shifts and
// a shift-add multiply. Operands are latched on an accepted START. Q/Carry/Zero are
// registered and change only in the cycle DONE pulses.
//
// Ports:
//   CLK    system clock, all state on the rising edge
//   RST    synchronous active-high reset
//   START  request, accepted only while BUSY=0
//   OP     4-bit opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 MUL,
//          9-15 pass A)
//   A, B   operands; B[SHW-1:0] is the shift amount for shifts
//   Q      registered result
//   Carry  carry / borrow / last shifted-out bit / multiply overflow
//   Zero   Q == 0 for the latched result
//   BUSY   multi-cycle op in progress
//   DONE   one-cycle pulse, result valid
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             Carry,
  output logic             Zero,
  output logic             BUSY,
  output logic             DONE
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so a count of WIDTH (MUL) fits without wrapping.
  localparam int CW  = SHW + 1;

  localparam logic StIdle = 1'b0;
  localparam logic StExec = 1'b1;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpMul = 4'd8;

  logic             state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // a_q: shift register for shifts, multiplicand for MUL.
  // b_q: multiplier, shifted right as product low bits enter from the top.
  // hi_q: upper half of the running product.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             finish;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   k;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    q_d     = q_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    res     = '0;
    res_c   = 1'b0;
    finish  = 1'b0;
    sum     = '0;
    k       = B[SHW-1:0];

    if (state_q == StIdle) begin
      if (START) begin
        op_d   = OP;
        a_d    = A;
        b_d    = B;
        hi_d   = '0;
        finish = 1'b1;
        case (OP)
          OpAdd: {res_c, res} = {1'b0, A} + {1'b0, B};
          OpSub: begin
            res   = A - B;
            res_c = (A < B);
          end
          OpAnd: res = A & B;
          OpOr:  res = A | B;
          OpXor: res = A ^ B;
          OpNot: res = ~A;
          OpShl, OpShr: begin
            if (k == '0) begin
              res = A;
            end else begin
              finish  = 1'b0;
              state_d = StExec;
              cnt_d   = CW'(k);
            end
          end
          OpMul: begin
            finish  = 1'b0;
            state_d = StExec;
            cnt_d   = CW'(WIDTH);
          end
          default: res = A;
        endcase
      end
    end else begin
      // START is ignored here; one step per cycle until the count runs out.
      cnt_d = cnt_q - CW'(1);
      case (op_q)
        OpShl: begin
          res_c = a_q[WIDTH-1];
          res   = a_q << 1;
          a_d   = res;
        end
        OpShr: begin
          res_c = a_q[0];
          res   = a_q >> 1;
          a_d   = res;
        end
        default: begin
          sum   = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
          hi_d  = sum[WIDTH:1];
          b_d   = {sum[0], b_q[WIDTH-1:1]};
          res   = b_d;
          res_c = |hi_d;
        end
      endcase
      if (cnt_q == CW'(1)) begin
        finish  = 1'b1;
        state_d = StIdle;
      end
    end

    if (finish) begin
      q_d     = res;
      carry_d = res_c;
      zero_d  = (res == '0);
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      q_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign Carry = carry_q;
  assign Zero  = zero_q;
  assign BUSY  = (state_q == StExec);
  assign DONE  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8. Expected results are pushed
// when an op is started and popped by a monitor on each DONE pulse.
module tb_alu_seq;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [3:0]   OP = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q;
  logic         Carry, Zero, BUSY, DONE;

  alu_seq #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .OP   (OP),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .Carry(Carry),
    .Zero (Zero),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] q;
    logic         c;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] hold_q = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model, written from the opcode definitions at WIDTH=8.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] q,
                                output logic c, output int lat);
    logic [15:0] t;
    int          k;
    k   = int'(b[2:0]);
    c   = 1'b0;
    lat = 1;
    case (op)
      4'd0: begin t = {8'd0, a} + {8'd0, b}; q = t[7:0]; c = t[8]; end
      4'd1: begin q = a - b; c = (a < b); end
      4'd2: q = a & b;
      4'd3: q = a | b;
      4'd4: q = a ^ b;
      4'd5: q = ~a;
      4'd6: begin
        t = {8'd0, a} << k;
        q = t[7:0];
        c = (k != 0) ? t[8] : 1'b0;
        lat = k + 1;
      end
      4'd7: begin
        t = {a, 8'd0} >> k;
        q = t[15:8];
        c = (k != 0) ? t[7] : 1'b0;
        lat = k + 1;
      end
      4'd8: begin
        t = a * b;
        q = t[7:0];
        c = |t[15:8];
        lat = W + 1;
      end
      default: q = a;
    endcase
  endfunction

  // Monitor: every DONE must match the oldest expectation, in the predicted cycle.
  always @(negedge CLK) begin
    if (mon_en && DONE === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", Q, e.q);
        check("carry", Carry, e.c);
        check("zero", Zero, e.z);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called just after a rising edge; START is held for exactly one cycle.
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
    exp_t e;
    model(op, a, b, e.q, e.c, lat);
    e.z   = (e.q == '0);
    e.cyc = cyc + lat;
    sb.push_back(e);
    hold_q = last_q;
    last_q = e.q;
    START = 1'b1;
    OP    = op;
    A     = a;
    B     = b;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
    end while (sb.size() != 0 && n < 200);
    #1;
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    int lat;
    start_op(op, a, b, lat);
    for (int i = 1; i < lat; i++) begin
      @(negedge CLK);
      check("busy", BUSY, 1);
      check("done_early", DONE, 0);
      check("q_hold", Q, hold_q);
      // A second request while busy must be ignored.
      START = inject && (i == 2);
      OP    = 4'd0;
      A     = 8'd1;
      B     = 8'd1;
    end
    START = 1'b0;
    @(negedge CLK);
    check("busy_on_done", BUSY, 0);
    wait_empty();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_q", Q, 0);
    check("rst_carry", Carry, 0);
    check("rst_zero", Zero, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    RST    = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    run_op(4'd0, 8'hFF, 8'h01, 1'b0);
    check("add_hold_done", DONE, 0);
    check("add_hold_q", Q, 8'h00);

    run_op(4'd1, 8'h05, 8'h07, 1'b0);
    run_op(4'd1, 8'h33, 8'h33, 1'b0);
    run_op(4'd5, 8'hA5, 8'h00, 1'b0);
    run_op(4'd2, 8'hF0, 8'h3C, 1'b0);
    run_op(4'd3, 8'h0F, 8'h30, 1'b0);
    run_op(4'd4, 8'hFF, 8'h5A, 1'b0);
    run_op(4'd12, 8'h77, 8'h11, 1'b0);
    run_op(4'd6, 8'h81, 8'h03, 1'b0);
    run_op(4'd7, 8'h01, 8'h01, 1'b0);
    run_op(4'd6, 8'hC3, 8'h08, 1'b0);
    run_op(4'd7, 8'h80, 8'h07, 1'b0);
    run_op(4'd6, 8'h01, 8'h07, 1'b0);
    run_op(4'd8, 8'h10, 8'h11, 1'b1);
    run_op(4'd8, 8'hFF, 8'hFF, 1'b0);

    // Back-to-back: next op accepted in the MUL's DONE cycle.
    start_op(4'd8, 8'h10, 8'h11, lat);
    repeat (8) @(posedge CLK);
    #1;
    start_op(4'd2, 8'hF0, 8'h3C, lat);
    wait_empty();

    // Reset in cycle 4 of a MUL: no DONE for it, everything cleared.
    START = 1'b1;
    OP    = 4'd8;
    A     = 8'h10;
    B     = 8'h11;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("abort_q", Q, 0);
    check("abort_carry", Carry, 0);
    check("abort_zero", Zero, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    last_q = '0;
    start_op(4'd0, 8'h02, 8'h03, lat);
    wait_empty();
    repeat (12) @(posedge CLK);
    #1;

    for (int i = 0; i < 24; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
